// File: rtl/gray_pkg.sv
// Shared constants for the gray-image engines: image geometry, pixel widths,
// neighbour address offsets and the arbiter port state encoding.
package gray_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_AW = 14;
    localparam int IMG_DW = 8;

    // Offsets from a centre address to its 8 neighbours in a row-major 128-wide image
    localparam int OFF_NW = -(IMG_W + 1);
    localparam int OFF_N  = -IMG_W;
    localparam int OFF_NE = -(IMG_W - 1);
    localparam int OFF_W  = -1;
    localparam int OFF_E  = 1;
    localparam int OFF_SW = IMG_W - 1;
    localparam int OFF_S  = IMG_W;
    localparam int OFF_SE = IMG_W + 1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gray_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr,
// wrapping modulo NREQ; returns one-hot grant and its index.
module rr_pick
    import gray_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    int   cand;
    logic found;

    // NOTE: every variable written here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = 0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/gray_port_arbiter.sv
// Shares the gray image memory read port between NREQ engines with round-robin
// fairness, an optional neighbourhood lock and a two-edge pipelined return path.
module gray_port_arbiter
    import gray_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = IMG_AW,
    parameter int DW   = IMG_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_grant,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_data
);

    localparam int PW = idx_width(NREQ);

    arb_state_e      state, state_next;
    logic [PW-1:0]   rr_ptr, owner, tag, win_idx;
    logic            tag_valid;
    logic [NREQ-1:0] eligible, pick_grant;
    logic            grant_any, win_lock;

    // While locked only the owner is eligible, even if it is idle this cycle
    always_comb begin
        eligible = '0;
        if (mem_req) begin
            if (state == ST_LOCKED) eligible = req_valid & (NREQ'(1) << owner);
            else                    eligible = req_valid;
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (win_idx)
    );

    assign req_grant = pick_grant;
    assign grant_any = |pick_grant;
    assign win_lock  = req_lock[win_idx];

    always_comb begin
        state_next = state;
        if (grant_any) begin
            if (state == ST_OPEN && win_lock)    state_next = ST_LOCKED;
            if (state == ST_LOCKED && !win_lock) state_next = ST_OPEN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_OPEN;
            rr_ptr    <= '0;
            owner     <= '0;
            tag       <= '0;
            tag_valid <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= state_next;
            mem_req   <= mem_req | mem_ready;
            tag_valid <= grant_any;
            if (grant_any) begin
                mem_addr <= req_addr[win_idx*AW +: AW];
                tag      <= win_idx;
                if (state == ST_OPEN) begin
                    rr_ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
                    if (win_lock) owner <= win_idx;
                end
            end
            rsp_valid <= tag_valid ? (NREQ'(1) << tag) : '0;
            if (tag_valid) rsp_data <= mem_data;
        end
    end

endmodule

// File: doc/gray_port_arbiter.md
Name: gray_port_arbiter

Overview:
- Shares the single read port of the gray image memory between NREQ image-processing engines (LBP cores, or LBP plus a preprocessing filter).
- Requesters issue one-address reads; the arbiter returns the pixel to the owning requester.
- Round-robin fairness between requesters.
- Optional lock lets one requester own the port for a whole neighbourhood fetch (centre plus 8 neighbours).
- Sits between the engines and the testbench-side gray_addr/gray_req/gray_ready/gray_data interface.

Parameters:
NREQ, 2, number of requesters (1..4)
AW, 14, pixel address width (128x128 image)
DW, 8, pixel data width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req_valid  input  NREQ  requester i presents a read
req_addr  input  NREQ*AW  address of requester i, slice [i*AW +: AW]
req_lock  input  NREQ  keep ownership after this beat
req_grant  output  NREQ  one-hot, combinational; read accepted this cycle
rsp_valid  output  NREQ  one-hot, registered; rsp_data belongs to requester i
rsp_data  output  DW  registered returned pixel, shared by all requesters
mem_ready  input  1  memory loaded (gray_ready)
mem_req  output  1  registered request to memory (gray_req)
mem_addr  output  AW  registered read address (gray_addr)
mem_data  input  DW  pixel at current mem_addr, same cycle (gray_data)

Behaviour:
- Reset values (reset low, async): mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rr_ptr=0, state=OPEN, owner=0, tag_valid=0.
- mem_req: set on the first edge with mem_ready=1, then sticky until reset.
- No grant while mem_req=0. A grant requires mem_req=1 and req_valid[winner]=1.
- State OPEN:
  - Winner is the first asserted req_valid searching from rr_ptr upward, wrapping modulo NREQ.
  - At the edge of a grant: mem_addr<=req_addr[winner], tag<=winner, tag_valid<=1, rr_ptr<=(winner+1) mod NREQ.
  - If req_lock[winner]=1: owner<=winner and state<=LOCKED.
- State LOCKED:
  - Only owner may be granted; all other requesters are stalled even when the owner's req_valid=0 (owner holds the port).
  - A grant with req_lock[owner]=0 is the final beat and sets state<=OPEN.
  - rr_ptr is not updated inside LOCKED.
- Data path:
  - One grant per cycle is sustained; the path is fully pipelined.
  - Edge k: grant captured. Cycle k..k+1: mem_data is valid for mem_addr.
  - Edge k+1: rsp_data<=mem_data and rsp_valid<=onehot(tag) if tag_valid, else 0.
  - Latency from grant cycle to rsp_valid is 2 edges.
- No grant in a cycle: mem_addr holds its value, tag_valid<=0.
- req_grant is a combinational function of req_valid, state, owner, rr_ptr and mem_req; it never depends on rsp or mem_data.
- Address is passed through unmodified; there is no bounds check. Requesters compute neighbour offsets (+/-1, +/-127, +/-128, +/-129) themselves.
- NREQ=1: degenerates to a pipelined pass-through; rr_ptr stays 0.
- Reset mid-transfer: in-flight tag dropped, no rsp_valid after reset release, lock cleared.

Decomposition:
- Shared package gray_pkg holds IMG_W=128, IMG_AW=14, IMG_DW=8 and the neighbour offset constants used by all engines.
- Sub-module rr_pick: a combinational NREQ-wide round-robin priority picker with inputs req and ptr and outputs one-hot grant plus index.
- The arbiter instantiates rr_pick; state, tag pipeline and memory registers stay in the top level.

Test Plan:
- Reset with mem_ready=0 and req_valid=2'b11 -> req_grant=0, mem_req stays 0. Raise mem_ready -> mem_req=1 next edge, then grants begin.
- Both requesters request continuously, no lock, addrs 0x0081/0x0102 -> grants alternate 01,10,01,...; rsp_valid follows each grant 2 edges later with the correct pixel.
- Req0 issues 9 beats around centre 0x0081 with lock=1 on beats 1-8 and lock=0 on beat 9, while req1 is held valid -> req1 never granted for 9 cycles, granted on cycle 10.
- Locked owner drops req_valid for 3 cycles mid-burst -> no grants to anyone for those cycles; lock resumes when valid returns.
- Reset pulsed low one cycle after a grant -> rsp_valid stays 0 after release, rr_ptr=0, state OPEN.
- Only req1 active, addr 0x3F7E (16254) -> mem_addr=0x3F7E after 1 edge; rsp_data=mem[16254] with rsp_valid=2'b10 after 2 edges.
